uart_rx: RTL and testbench
==========================

Name:
uart_rx

Overview:
- UART receiver; the receiving end of the team's 8-N-1 serial link.
- Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Samples the asynchronous serial line at mid-bit and presents each received byte with a one-cycle valid pulse.
- Flags framing errors (and parity errors when compiled in).
- Sits directly behind the board RX pin, feeding command parsers or FIFOs.

Parameters:
- CLKS_PER_BIT, 217: i_Clock cycles per bit = f(i_Clock)/baud; legal range 4..65535.

Ports:
- i_Clock  input  1  system clock; all logic on the rising edge.
- i_Rst  input  1  synchronous active-high reset.
- i_RX_Serial  input  1  asynchronous serial line; idles high.
- o_RX_DV  output  1  one-cycle pulse; o_RX_Byte is valid for this byte.
- o_RX_Byte  output  8  last good received byte; held until the next good byte.
- o_RX_Active  output  1  high while a frame is in progress (START through STOP).
- o_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled as 0.

Behaviour:
- Clocking and reset
  - One clock domain.
  - Reset is synchronous, active-high, and takes priority over all other logic.
  - On reset: state=IDLE, counters=0, o_RX_DV=0, o_RX_Byte=8'h00, o_RX_Active=0, o_Frame_Err=0, synchronizer flops=1.
- Input synchronizer
  - i_RX_Serial passes through a 2-flop synchronizer; all FSM decisions use the synced bit (rx_s).
  - This adds 2 cycles of latency from the pin.
- Counters
  - Bit-period counter: width $clog2(CLKS_PER_BIT)+1, counts 0..CLKS_PER_BIT-1.
  - Bit index: 3 bits.
- FSM states: IDLE, START, DATA, [PARITY], STOP, CLEANUP, WAIT_HIGH.
- IDLE
  - Counters=0.
  - rx_s==0 -> START.
- START
  - Count to (CLKS_PER_BIT-1)/2 (integer division).
  - At that count:
    - rx_s==0 -> DATA, counter=0, o_RX_Active=1.
    - rx_s==1 -> IDLE (glitch/false start); no output activity, o_RX_Active never asserts.
- DATA
  - Count to CLKS_PER_BIT-1.
  - At terminal count: shift rx_s into data bit[index], counter=0.
  - index<7 -> index+1; index==7 -> index=0, go to PARITY if enabled else STOP.
- STOP
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s==1: o_RX_Byte<=shift data, o_RX_DV=1 for exactly one cycle (unless a parity error is flagged) -> CLEANUP.
  - rx_s==0: o_Frame_Err=1 for one cycle, o_RX_Byte unchanged, no DV -> WAIT_HIGH.
  - o_RX_Active drops in the same cycle the DV or error pulse rises.
- CLEANUP
  - One cycle; pulses cleared -> IDLE.
- WAIT_HIGH
  - Stay until rx_s==1 (break or line held low), then -> IDLE.
  - Guarantees no spurious start detection during a break.
- Timing
  - Sampling is at mid-bit: the start is qualified half a bit after the falling edge, and each later sample is one full bit after the previous one.
  - Back-to-back frames (stop bit immediately followed by start bit) must be received without loss.
  - DV rises at 2+(CLKS_PER_BIT-1)/2+9*CLKS_PER_BIT+1 cycles ±1 after the pin falling edge (parity off).
- Reset mid-frame
  - Immediate return to IDLE with the reset values.
  - A partial byte is discarded; o_RX_Byte is cleared to 8'h00.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, plus output o_Parity_Err (1 bit).
  - PARITY counts CLKS_PER_BIT-1, samples rx_s and compares it with the even parity of the 8 data bits (XOR of data ^ parity bit must be 0).
  - At the STOP sample: a mismatch with stop==1 gives an o_Parity_Err one-cycle pulse, no DV, and o_RX_Byte unchanged.
  - A framing error takes precedence: only o_Frame_Err pulses.
  - o_Parity_Err reset value is 0.
- Undefined:
  - No PARITY state, no o_Parity_Err port; the frame is 10 bits.

Test Plan:
- CLKS_PER_BIT=8, send 0x5A framed correctly -> exactly one o_RX_DV pulse, o_RX_Byte=0x5A, o_Frame_Err never high, o_RX_Active high only during the frame.
- Send 0x00, 0xFF, 0xA5 back-to-back with no idle gap -> three DV pulses carrying 0x00, 0xFF, 0xA5 in order.
- Line low for 2 clocks then high -> FSM returns to IDLE, no DV, no error, o_RX_Active stays 0.
- Send 0x3C with stop bit=0, then hold the line low for 40 clocks, then send 0x11 -> one o_Frame_Err pulse, o_RX_Byte stays at its prior value, no start detected during the low hold, then DV with 0x11.
- Assert i_Rst during data bit 4 of 0x77, release, send 0x42 -> outputs at reset values, no DV for 0x77, then DV with 0x42.
- UART_RX_PARITY_EN defined: 0x03 with parity=0 -> DV, 0x03; 0x03 with parity=1 -> o_Parity_Err pulse, no DV.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Receiver for the 8-N-1 serial link. The asynchronous line is brought into
//   the i_Clock domain by a two-flop synchronizer. Each bit is then sampled at
//   its midpoint. A received byte is presented with a one-cycle o_RX_DV pulse.
//   A stop bit sampled as 0 produces a one-cycle o_Frame_Err pulse instead.
//
//   Optional build macro: UART_RX_PARITY_EN
//     When defined, an even-parity bit follows the data bits and o_Parity_Err
//     is added. When undefined, the frame is 10 bits with no parity.
//
// Parameters
//   CLKS_PER_BIT  i_Clock cycles per serial bit (legal 4..65535)
//
// Ports
//   i_Clock       system clock, rising edge
//   i_Rst         synchronous active-high reset
//   i_RX_Serial   asynchronous serial input, idles high
//   o_RX_DV       one-cycle pulse, o_RX_Byte holds a new good byte
//   o_RX_Byte     last good byte, held until the next good byte
//   o_RX_Active   high from start-bit qualification until the stop sample
//   o_Frame_Err   one-cycle pulse when the stop bit is sampled low
//   o_Parity_Err  (UART_RX_PARITY_EN only) one-cycle pulse on parity mismatch
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_Frame_Err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_Parity_Err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
`endif
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_CLEANUP   = 3'd5;
  localparam logic [2:0] S_WAIT_HIGH = 3'd6;

  logic             rx_p0;
  logic             rx_p1;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_data;
`ifdef UART_RX_PARITY_EN
  logic             parity_bad;

  // Even parity: XOR of the data bits and the parity bit must be zero.
  function automatic logic parity_mismatch(input logic [7:0] data, input logic par);
    return (^data) ^ par;
  endfunction
`endif

  // Stage p0/p1: two-flop synchronizer; idle-high reset keeps IDLE from
  // seeing a false start as reset releases.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= i_RX_Serial;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // Receive FSM: all decisions use the synchronized bit.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= 3'd0;
      o_RX_DV     <= 1'b0;
      o_RX_Byte   <= 8'h00;
      o_RX_Active <= 1'b0;
      o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_Parity_Err <= 1'b0;
      parity_bad   <= 1'b0;
`endif
    end else begin
      // Status outputs are pulses: low unless set below this cycle.
      o_RX_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_Parity_Err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= 3'd0;
          if (!rx_s) state <= S_START;
        end

        S_START: begin
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            // A line that is back high at mid start bit was a glitch.
            if (!rx_s) begin
              state       <= S_DATA;
              o_RX_Active <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state   <= S_PARITY;
`else
              state   <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt    <= '0;
            parity_bad <= parity_mismatch(shift_data, rx_s);
            state      <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt     <= '0;
            o_RX_Active <= 1'b0;
            if (rx_s) begin
              state <= S_CLEANUP;
`ifdef UART_RX_PARITY_EN
              if (parity_bad) begin
                o_Parity_Err <= 1'b1;
              end else begin
                o_RX_DV   <= 1'b1;
                o_RX_Byte <= shift_data;
              end
`else
              o_RX_DV   <= 1'b1;
              o_RX_Byte <= shift_data;
`endif
            end else begin
              // Framing error wins over any parity result.
              o_Frame_Err <= 1'b1;
              state       <= S_WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        S_CLEANUP: begin
          state <= S_IDLE;
        end

        // Hold off start detection until a break or stuck-low line releases.
        S_WAIT_HIGH: begin
          if (rx_s) state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Data shift register: every frame overwrites all eight bits before use,
  // so it needs no reset.
  always_ff @(posedge i_Clock) begin
    if (state == S_DATA && clk_cnt == LAST_CNT) begin
      shift_data[bit_idx] <= rx_s;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int C = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam int NBITS    = PAR_ON ? 10 : 9;          // bits after start, stop excluded
  localparam int FRAME_ACT = NBITS * C;               // cycles o_RX_Active is high per frame
  localparam int LAT      = 2 + (C - 1) / 2 + NBITS * C + 1;

  logic       i_Clock;
  logic       i_Rst;
  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Active;
  logic       o_Frame_Err;
  logic       o_Parity_Err;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock     (i_Clock),
    .i_Rst       (i_Rst),
    .i_RX_Serial (i_RX_Serial),
    .o_RX_DV     (o_RX_DV),
    .o_RX_Byte   (o_RX_Byte),
    .o_RX_Active (o_RX_Active),
    .o_Frame_Err (o_Frame_Err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_Parity_Err(o_Parity_Err)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign o_Parity_Err = 1'b0;
`endif

  initial begin
    i_Clock = 1'b0;
    forever #5 i_Clock = ~i_Clock;
  end

  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  logic [7:0] dv_q[$];
  int         dv_cyc_q[$];
  int         fe_cnt, pe_cnt, act_cnt, wide_cnt;
  logic       dv_prev, fe_prev, pe_prev;

  initial begin
    fe_cnt = 0; pe_cnt = 0; act_cnt = 0; wide_cnt = 0;
    dv_prev = 1'b0; fe_prev = 1'b0; pe_prev = 1'b0;
  end

  always @(negedge i_Clock) begin
    if (o_RX_DV === 1'b1) begin
      dv_q.push_back(o_RX_Byte);
      dv_cyc_q.push_back(cyc);
    end
    if (o_Frame_Err === 1'b1) fe_cnt++;
    if (o_Parity_Err === 1'b1) pe_cnt++;
    if (o_RX_Active === 1'b1) act_cnt++;
    if ((o_RX_DV === 1'b1 && dv_prev) || (o_Frame_Err === 1'b1 && fe_prev) ||
        (o_Parity_Err === 1'b1 && pe_prev)) wide_cnt++;
    dv_prev <= (o_RX_DV === 1'b1);
    fe_prev <= (o_Frame_Err === 1'b1);
    pe_prev <= (o_Parity_Err === 1'b1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic clear_mon();
    dv_q.delete();
    dv_cyc_q.delete();
    fe_cnt = 0; pe_cnt = 0; act_cnt = 0;
  endtask

  int start_cyc;

  task automatic put_bit(input logic v);
    i_RX_Serial = v;
    repeat (C) @(posedge i_Clock);
    #1;
  endtask

  task automatic idle(input int n);
    i_RX_Serial = 1'b1;
    repeat (n) @(posedge i_Clock);
    #1;
  endtask

  // Leaves the line at the stop-bit value.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
    start_cyc = cyc;
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(d[i]);
    if (PAR_ON) put_bit((^d) ^ flip);
    put_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;      // extra low cycles after a bad stop bit
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[6];

  logic [7:0] exp_q[$];
  logic [7:0] exp_last;
  int         exp_fe, exp_pe;

  initial begin
    i_Rst = 1'b1;
    i_RX_Serial = 1'b1;
    vecs[0] = '{8'h5A, 1'b1, 0,  1, 0, 8'h5A};
    vecs[1] = '{8'h80, 1'b1, 0,  1, 0, 8'h80};
    vecs[2] = '{8'h01, 1'b1, 0,  1, 0, 8'h01};
    vecs[3] = '{8'h3C, 1'b0, 40, 0, 1, 8'h01};
    vecs[4] = '{8'h11, 1'b1, 0,  1, 0, 8'h11};
    vecs[5] = '{8'hC3, 1'b1, 0,  1, 0, 8'hC3};

    // Reset state
    repeat (3) @(posedge i_Clock);
    #1;
    check("reset_dv",     int'(o_RX_DV),      0);
    check("reset_byte",   int'(o_RX_Byte),    0);
    check("reset_active", int'(o_RX_Active),  0);
    check("reset_ferr",   int'(o_Frame_Err),  0);
    check("reset_perr",   int'(o_Parity_Err), 0);
    i_Rst = 1'b0;
    idle(2 * C);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      repeat (vecs[i].hold) @(posedge i_Clock);
      #1;
      idle(3 * C);
      check($sformatf("vec%0d_dv_count", i), dv_q.size(), vecs[i].exp_dv);
      check($sformatf("vec%0d_ferr_count", i), fe_cnt, vecs[i].exp_fe);
      check($sformatf("vec%0d_byte", i), int'(o_RX_Byte), int'(vecs[i].exp_byte));
      check($sformatf("vec%0d_active_cycles", i), act_cnt, FRAME_ACT);
      check($sformatf("vec%0d_active_after", i), int'(o_RX_Active), 0);
      if (i == 0) begin
        n_checks++;
        if (dv_cyc_q.size() == 0)
          $display("FAIL dv_latency: got no DV required %0d +-1 cycles", LAT);
        else if ((dv_cyc_q[0] - start_cyc - 1) >= LAT - 1 && (dv_cyc_q[0] - start_cyc - 1) <= LAT + 1)
          n_pass++;
        else
          $display("FAIL dv_latency: got %0d required %0d +-1 cycles", dv_cyc_q[0] - start_cyc - 1, LAT);
      end
    end

    // Back-to-back frames with no idle gap
    clear_mon();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(3 * C);
    check("b2b_count", dv_q.size(), 3);
    if (dv_q.size() == 3) begin
      check("b2b_byte0", int'(dv_q[0]), 8'h00);
      check("b2b_byte1", int'(dv_q[1]), 8'hFF);
      check("b2b_byte2", int'(dv_q[2]), 8'hA5);
    end
    check("b2b_active_cycles", act_cnt, 3 * FRAME_ACT);

    // Glitch: line low for 2 clocks only
    clear_mon();
    i_RX_Serial = 1'b0;
    repeat (2) @(posedge i_Clock);
    #1;
    idle(3 * C);
    check("glitch_dv", dv_q.size(), 0);
    check("glitch_ferr", fe_cnt, 0);
    check("glitch_active", act_cnt, 0);
    check("glitch_byte_held", int'(o_RX_Byte), 8'hA5);

    // Reset during data bit 4 of 0x77, then a clean 0x42
    clear_mon();
    i_RX_Serial = 1'b0;
    repeat (C) @(posedge i_Clock);
    #1;
    for (int i = 0; i < 4; i++) put_bit(1'(8'h77 >> i));
    i_RX_Serial = 1'b1;     // bit 4 of 0x77
    repeat (C / 2) @(posedge i_Clock);
    #1;
    i_Rst = 1'b1;
    repeat (2) @(posedge i_Clock);
    #1;
    check("midrst_dv",     int'(o_RX_DV),     0);
    check("midrst_byte",   int'(o_RX_Byte),   0);
    check("midrst_active", int'(o_RX_Active), 0);
    check("midrst_ferr",   int'(o_Frame_Err), 0);
    repeat (C) @(posedge i_Clock);
    #1;
    i_Rst = 1'b0;
    idle(2 * C);
    check("midrst_no_dv", dv_q.size(), 0);
    clear_mon();
    send_frame(8'h42, 1'b1, 1'b0);
    idle(3 * C);
    check("post_rst_count", dv_q.size(), 1);
    if (dv_q.size() == 1) check("post_rst_byte", int'(dv_q[0]), 8'h42);
    check("post_rst_ferr", fe_cnt, 0);
    exp_last = 8'h42;

`ifdef UART_RX_PARITY_EN
    // Parity: good, bad, and bad parity hidden behind a framing error
    clear_mon();
    send_frame(8'h03, 1'b1, 1'b0);
    idle(3 * C);
    check("par_good_dv", dv_q.size(), 1);
    check("par_good_byte", int'(o_RX_Byte), 8'h03);
    check("par_good_perr", pe_cnt, 0);
    clear_mon();
    send_frame(8'h03, 1'b1, 1'b1);
    idle(3 * C);
    check("par_bad_dv", dv_q.size(), 0);
    check("par_bad_perr", pe_cnt, 1);
    check("par_bad_byte_held", int'(o_RX_Byte), 8'h03);
    clear_mon();
    send_frame(8'h55, 1'b0, 1'b1);
    idle(3 * C);
    check("par_frame_ferr", fe_cnt, 1);
    check("par_frame_perr", pe_cnt, 0);
    check("par_frame_dv", dv_q.size(), 0);
    exp_last = 8'h03;
`endif

    // Randomized frames against a frame-level reference model
    clear_mon();
    exp_q.delete();
    exp_fe = 0;
    exp_pe = 0;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic       stop, flip;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      flip = ($urandom_range(0, 3) == 0);
      send_frame(d, stop, flip);
      if (!stop) begin
        repeat ($urandom_range(0, 30)) @(posedge i_Clock);
        #1;
        idle(C);
      end else begin
        idle($urandom_range(0, 2 * C));
      end
      if (!stop) exp_fe++;
      else if (PAR_ON && flip) exp_pe++;
      else begin
        exp_q.push_back(d);
        exp_last = d;
      end
    end
    idle(3 * C);
    check("rand_dv_count", dv_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dv_q.size(); i++)
      check($sformatf("rand_byte%0d", i), int'(dv_q[i]), int'(exp_q[i]));
    check("rand_ferr_count", fe_cnt, exp_fe);
    check("rand_perr_count", pe_cnt, exp_pe);
    check("rand_last_byte", int'(o_RX_Byte), int'(exp_last));
    check("pulse_width", wide_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
